// File: rtl/gpu_pkg.sv
// Shared 640x480 text-mode constants, fetch phase names, cell attribute layout and CGA palette.
package gpu_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;
  localparam int unsigned CELL_W    = 8;
  localparam int unsigned CELL_H    = 16;

  // Position within an 8-pixel cell, taken directly from cycle[2:0].
  typedef enum logic [2:0] {
    PH_ADDR  = 3'd0,
    PH_WAIT1 = 3'd1,
    PH_CHAR  = 3'd2,
    PH_WAIT3 = 3'd3,
    PH_GLYPH = 3'd4,
    PH_IDLE5 = 3'd5,
    PH_IDLE6 = 3'd6,
    PH_LOAD  = 3'd7
  } phase_t;

  // Same bit order as vram_data[15:8]: background in the upper nibble.
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
  } attr_t;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      default: rgb = 12'hFFF;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/text_cell_fetch.sv
// One-cell-ahead VRAM/font fetch sequencer producing the next cell's glyph row and attribute.
// TEXT_CURSOR_EN adds cursor position inputs and a per-cell cursor-hit flag.
module text_cell_fetch
  import gpu_pkg::*;
#(
  parameter int unsigned VRAM_BASE = 0,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [9:0]        cycle,
  input  logic [8:0]        scanline,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [15:0]       vram_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic              pending_cursor,
`endif
  output logic [7:0]        pending_bits,
  output logic [7:0]        pending_attr
);

  phase_t            phase;
  logic              last_slot;
  logic [9:0]        line_next;
  logic [9:0]        fl;
  logic [6:0]        fc;
  logic [4:0]        row;
  logic [11:0]       row_x80;
  logic [ADDR_W-1:0] cell_addr;
  logic              valid;

  logic              fetch_valid;
  logic [7:0]        fetch_attr;
`ifdef TEXT_CURSOR_EN
  logic              fetch_cursor;
`endif

  // The last cell slot of a line pre-fetches column 0 of the following line.
  always_comb begin
    phase     = phase_t'(cycle[2:0]);
    last_slot = (cycle >= 10'(H_TOTAL - CELL_W));
    line_next = {1'b0, scanline} + 10'd1;
    if (line_next == 10'(V_TOTAL))
      line_next = '0;
    fl        = last_slot ? line_next : {1'b0, scanline};
    fc        = last_slot ? '0 : (cycle[9:3] + 7'd1);
    valid     = (fc < 7'(TEXT_COLS)) && (fl < 10'(V_VISIBLE));
    row       = fl[8:4];
    row_x80   = {1'b0, row, 6'b0} + {3'b0, row, 4'b0};
    cell_addr = ADDR_W'(VRAM_BASE) + ADDR_W'(row_x80) + ADDR_W'(fc);
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      vram_addr    <= '0;
      vram_rd      <= 1'b0;
      font_addr    <= '0;
      fetch_valid  <= 1'b0;
      fetch_attr   <= '0;
      pending_bits <= '0;
      pending_attr <= '0;
`ifdef TEXT_CURSOR_EN
      fetch_cursor   <= 1'b0;
      pending_cursor <= 1'b0;
`endif
    end else begin
      vram_rd <= 1'b0;
      case (phase)
        PH_ADDR: begin
          vram_addr   <= cell_addr;
          vram_rd     <= valid;
          fetch_valid <= valid;
`ifdef TEXT_CURSOR_EN
          fetch_cursor <= (fc == cursor_col) && (row == cursor_row);
`endif
        end
        PH_CHAR: begin
          fetch_attr <= vram_data[15:8];
          font_addr  <= {vram_data[7:0], fl[3:0]};
        end
        PH_GLYPH: begin
          pending_bits <= fetch_valid ? font_data  : '0;
          pending_attr <= fetch_valid ? fetch_attr : '0;
`ifdef TEXT_CURSOR_EN
          pending_cursor <= fetch_valid && fetch_cursor;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_renderer.sv
// 80x30 text-mode pixel generator: cell shifter, palette lookup and 1-clock sync delay.
// TEXT_CURSOR_EN adds cursor_col/cursor_row and a blinking inverse-video cursor.
module text_renderer
  import gpu_pkg::*;
#(
  parameter int unsigned VRAM_BASE = 0,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [9:0]        cycle,
  input  logic [8:0]        scanline,
  input  logic              blank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  input  logic [15:0]       vram_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
`endif
  output logic [11:0]       rgb,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_out
);

  logic [7:0] pending_bits;
  logic [7:0] pending_attr;
  logic [7:0] shifter;
  attr_t      shift_attr;
  phase_t     phase;
  logic       swap;
  logic [3:0] colour_idx;
`ifdef TEXT_CURSOR_EN
  logic       pending_cursor;
  logic       shift_cursor;
  logic [4:0] frame_cnt;
`endif

  text_cell_fetch #(
    .VRAM_BASE (VRAM_BASE),
    .ADDR_W    (ADDR_W)
  ) u_fetch (
    .pixel_clk      (pixel_clk),
    .rst            (rst),
    .cycle          (cycle),
    .scanline       (scanline),
    .vram_addr      (vram_addr),
    .vram_rd        (vram_rd),
    .vram_data      (vram_data),
    .font_addr      (font_addr),
    .font_data      (font_data),
`ifdef TEXT_CURSOR_EN
    .cursor_col     (cursor_col),
    .cursor_row     (cursor_row),
    .pending_cursor (pending_cursor),
`endif
    .pending_bits   (pending_bits),
    .pending_attr   (pending_attr)
  );

  always_comb begin
    phase = phase_t'(cycle[2:0]);
`ifdef TEXT_CURSOR_EN
    swap = shift_cursor && frame_cnt[4];
`else
    swap = 1'b0;
`endif
    // Inverting the selected bit is equivalent to exchanging fg and bg.
    colour_idx = (shifter[7] ^ swap) ? shift_attr.fg : shift_attr.bg;
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      shifter    <= '0;
      shift_attr <= '0;
      rgb        <= '0;
      hs_out     <= 1'b1;
      vs_out     <= 1'b1;
      blank_out  <= 1'b1;
    end else begin
      hs_out    <= hs_in;
      vs_out    <= vs_in;
      blank_out <= blank_in;
      rgb       <= blank_in ? '0 : palette(colour_idx);
      if (phase == PH_LOAD) begin
        shifter    <= pending_bits;
        shift_attr <= attr_t'(pending_attr);
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

`ifdef TEXT_CURSOR_EN
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      shift_cursor <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (phase == PH_LOAD)
        shift_cursor <= pending_cursor;
      if ((scanline == 9'(V_VISIBLE)) && (cycle == '0))
        frame_cnt <= frame_cnt + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: random VRAM/font contents against a per-pixel reference model.
module tb_text_renderer;

  localparam int unsigned BASE    = 'h0100;
  localparam int          CUR_COL = 3;
  localparam int          CUR_ROW = 2;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [9:0]  cycle;
  logic [8:0]  scanline;
  logic        blank_in, hs_in, vs_in;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [15:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] rgb;
  logic        hs_out, vs_out, blank_out;
`ifdef TEXT_CURSOR_EN
  logic [6:0]  cursor_col = 7'(CUR_COL);
  logic [4:0]  cursor_row = 5'(CUR_ROW);
`endif

  text_renderer #(
    .VRAM_BASE (BASE),
    .ADDR_W    (16)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .cycle      (cycle),
    .scanline   (scanline),
    .blank_in   (blank_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .vram_addr  (vram_addr),
    .vram_rd    (vram_rd),
    .vram_data  (vram_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
`ifdef TEXT_CURSOR_EN
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
`endif
    .rgb        (rgb),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .blank_out  (blank_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  logic [15:0] vmem [65536];
  logic [7:0]  font [4096];
  logic [11:0] pal  [16];

  // Synchronous memories: address seen on one edge, data visible on the next.
  always @(posedge pixel_clk) begin
    vram_data <= vmem[vram_addr];
    font_data <= font[font_addr];
  end

  int total = 0;
  int bad   = 0;
  int fcnt  = 0;
  int exp_addr = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Colour of screen pixel (c, s) straight from VRAM/font contents.
  function automatic logic [11:0] exp_pixel(input int c, input int s);
    logic [15:0] word;
    logic [7:0]  glyph;
    logic        b;
    logic [3:0]  fg, bg, t;
    if (c >= 640 || s >= 480) return 12'h000;
    word  = vmem[(BASE + (s / 16) * 80 + c / 8) % 65536];
    glyph = font[int'(word[7:0]) * 16 + s % 16];
    b     = glyph[7 - c % 8];
    fg    = word[11:8];
    bg    = word[15:12];
`ifdef TEXT_CURSOR_EN
    if (c / 8 == CUR_COL && s / 16 == CUR_ROW && (fcnt % 32) >= 16) begin
      t = fg; fg = bg; bg = t;
    end
`else
    t = '0;
`endif
    return b ? pal[fg] : pal[bg];
  endfunction

  task automatic sample(input int c, input int s, input bit fresh);
    logic       bl, hs, vs, fvalid;
    int         fl, fc;
    logic [11:0] want_rgb;
    bl = (c >= 640 || s >= 480) ? 1'b1 :
         (c >= 100 && c < 600 && $urandom_range(0, 15) == 0);
    hs = !(c >= 656 && c < 752);
    vs = !(s == 490 || s == 491);
    cycle = 10'(c); scanline = 9'(s);
    blank_in = bl; hs_in = hs; vs_in = vs;
    @(posedge pixel_clk);
    #1;
    want_rgb = (bl || fresh) ? 12'h000 : exp_pixel(c, s);
    check("rgb", 16'(rgb), 16'(want_rgb));
    check("hs_out", 16'(hs_out), 16'(hs));
    check("vs_out", 16'(vs_out), 16'(vs));
    check("blank_out", 16'(blank_out), 16'(bl));
    fl = (c >= 792) ? ((s + 1 == 525) ? 0 : s + 1) : s;
    fc = (c >= 792) ? 0 : c / 8 + 1;
    fvalid = (fc < 80) && (fl < 480);
    if (c % 8 == 0) begin
      exp_addr = (BASE + ((fl / 16) % 32) * 80 + fc) % 65536;
      check("vram_rd_p0", 16'(vram_rd), 16'(fvalid));
    end else begin
      check("vram_rd_idle", 16'(vram_rd), 16'h0);
    end
    check("vram_addr", vram_addr, 16'(exp_addr));
    if (c % 8 == 2 && fvalid)
      check("font_addr", 16'(font_addr), 16'({vmem[exp_addr][7:0], 4'(fl % 16)}));
    if (s == 1 && c == 0 && !bl) check("px_0_1", 16'(rgb), 16'h0FFF);
    if (s == 1 && c >= 1 && c <= 7 && !bl) check("px_n_1", 16'(rgb), 16'h000A);
    if (s == 17 && c == 792) check("addr_row1", vram_addr, 16'(BASE + 80));
    if (s == 479 && c == 624) check("addr_last", vram_addr, 16'(BASE + 2399));
    if (c == 0 && s == 480) fcnt++;
  endtask

  task automatic run(input int s0, input int c0, input int n, input bit fresh_start);
    int c = c0;
    int s = s0;
    for (int i = 0; i < n; i++) begin
      sample(c, s, fresh_start && i < 8);
      c++;
      if (c == 800) begin
        c = 0;
        s = (s + 1 == 525) ? 0 : s + 1;
      end
    end
  endtask

  initial begin
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 65536; i++) vmem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++)  font[i] = 8'($urandom);
    vmem[BASE] = 16'h1F41;
    for (int k = 0; k < 16; k++) font[16'h41 * 16 + k] = 8'h80;
`ifdef TEXT_CURSOR_EN
    vmem[BASE + CUR_ROW * 80 + CUR_COL] = 16'h0741;
`endif

    // Held in reset mid-frame with active syncs: outputs stay at reset values.
    rst = 1'b0;
    cycle = 10'd300; scanline = 9'd40;
    blank_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pixel_clk);
      #1;
      check("rst_rgb", 16'(rgb), 16'h0);
      check("rst_addr", vram_addr, 16'h0);
      check("rst_rd", 16'(vram_rd), 16'h0);
      check("rst_font", 16'(font_addr), 16'h0);
      check("rst_hs", 16'(hs_out), 16'h1);
      check("rst_vs", 16'(vs_out), 16'h1);
      check("rst_blank", 16'(blank_out), 16'h1);
      cycle = 10'(cycle + 10'd1);
    end
    rst = 1'b1;
    exp_addr = 0;

    run(0, 0, 1600, 1'b1);
    run(15, 784, 16 + 800 * 3, 1'b0);
    run(477, 784, 16 + 800 * 4, 1'b0);
    run(510, 784, 16 + 800, 1'b0);
`ifdef TEXT_CURSOR_EN
    run(31, 784, 16 + 800, 1'b0);
    while (fcnt % 32 < 16) begin
      sample(0, 480, 1'b0);
      sample(1, 480, 1'b0);
    end
    run(31, 784, 16 + 800, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
